// File: rtl/rv32i_multicycle_pkg.sv
// Shared types for the RV32I multicycle control unit:
// FSM states, datapath select encodings, opcodes and ALU ops.
package rv32i_multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH         = 4'h0,
    S_DECODE        = 4'h1,
    S_EXECUTE_R     = 4'h2,
    S_EXECUTE_I     = 4'h3,
    S_ALU_WRITEBACK = 4'h4,
    S_MEM_ADDR      = 4'h5,
    S_MEM_READ      = 4'h6,
    S_MEM_WRITE     = 4'h7,
    S_MEM_WRITEBACK = 4'h8,
    S_BRANCH        = 4'h9,
    S_JAL           = 4'hA,
    S_JALR          = 4'hB,
    S_LINK          = 4'hC,
    S_LUI           = 4'hD,
    S_AUIPC         = 4'hE,
    S_ERROR         = 4'hF
  } state_e;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'd0,
    SRC_A_RF     = 2'd1,
    SRC_A_OLD_PC = 2'd2,
    SRC_A_ZERO   = 2'd3
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RF   = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2
  } alu_src_b_e;

  typedef enum logic [1:0] {
    RES_ALU      = 2'd0,
    RES_MEM_DATA = 2'd1,
    RES_ALU_LAST = 2'd2
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  typedef enum logic {
    MEM_SRC_PC     = 1'b0,
    MEM_SRC_RESULT = 1'b1
  } mem_src_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    CLS_ADD = 2'd0,
    CLS_SUB = 2'd1,
    CLS_R   = 2'd2,
    CLS_I   = 2'd3
  } alu_cls_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

endpackage

// File: rtl/rv32i_alu_decoder.sv
// ALU operation decoder: op class plus funct3/funct7[5]
// to the ALU control code.
module rv32i_alu_decoder
  import rv32i_multicycle_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  alu_cls_e              cls,
  input  logic [2:0]            funct3,
  input  logic                  f7_b5,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  alu_op_e op_w;

  // map class and function fields to an ALU op
  always_comb begin
    op_w = ALU_ADD;
    unique case (cls)
      CLS_ADD: op_w = ALU_ADD;
      CLS_SUB: op_w = ALU_SUB;
      default: begin
        unique case (funct3)
          3'b000:  op_w = (cls == CLS_R && f7_b5) ? ALU_SUB : ALU_ADD;
          3'b001:  op_w = ALU_SLL;
          3'b010:  op_w = ALU_SLT;
          3'b011:  op_w = ALU_SLTU;
          3'b100:  op_w = ALU_XOR;
          3'b101:  op_w = f7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  op_w = ALU_OR;
          default: op_w = ALU_AND;
        endcase
      end
    endcase
    alu_control = ALU_CTRL_W'(op_w);
  end

endmodule

// File: rtl/rv32i_multicycle_controller.sv
// RV32I multicycle control FSM: datapath selects, enables,
// memory handshake with timeout, stall and sticky error.
module rv32i_multicycle_controller
  import rv32i_multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 16,
  parameter int STRICT_DECODE = 1,
  parameter int ALU_CTRL_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  alu_zero,
  input  logic                  alu_lt,
  input  logic                  alu_ltu,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_wr_ena,
  output logic                  mem_src,
  output logic                  PC_ena,
  output logic                  IR_write,
  output logic                  ALU_ena,
  output logic                  mem_data_ena,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [2:0]            immediate_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  jalr_clr_lsb,
  output logic                  instr_retired,
  output logic                  error,
  output logic [3:0]            state
);

  localparam int CNT_W =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM =
    CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_src_a_e       a_sel;
  alu_src_b_e       b_sel;
  result_src_e      res_sel;
  imm_src_e         imm_sel;
  mem_src_e         msrc;
  alu_cls_e         cls;
  logic             br_taken, br_bad;
  logic             f7_ok, mem_st, go;

  rv32i_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .cls         (cls),
    .funct3      (funct3),
    .f7_b5       (funct7[5]),
    .alu_control (alu_control)
  );

  // state register and wait-state counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // branch condition from funct3 and ALU flags
  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    unique case (funct3)
      3'b000:  br_taken = alu_zero;
      3'b001:  br_taken = !alu_zero;
      3'b100:  br_taken = alu_lt;
      3'b101:  br_taken = !alu_lt;
      3'b110:  br_taken = alu_ltu;
      3'b111:  br_taken = !alu_ltu;
      default: br_bad   = 1'b1;
    endcase
  end

  assign f7_ok  = (STRICT_DECODE == 0) ||
                  (funct7 == 7'h00) || (funct7 == 7'h20);
  assign mem_st = (state_q == S_FETCH) ||
                  (state_q == S_MEM_READ) ||
                  (state_q == S_MEM_WRITE);
  assign go     = ena && rst;

  // next state, selects and strobes
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    mem_req       = 1'b0;
    mem_wr_ena    = 1'b0;
    PC_ena        = 1'b0;
    IR_write      = 1'b0;
    ALU_ena       = 1'b0;
    mem_data_ena  = 1'b0;
    reg_write     = 1'b0;
    instr_retired = 1'b0;
    jalr_clr_lsb  = 1'b0;
    a_sel         = SRC_A_PC;
    b_sel         = SRC_B_RF;
    res_sel       = RES_ALU;
    imm_sel       = IMM_I;
    msrc          = MEM_SRC_PC;
    cls           = CLS_ADD;
    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        b_sel   = SRC_B_FOUR;
        if (mem_ready) begin
          IR_write = 1'b1;
          PC_ena   = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        a_sel   = SRC_A_OLD_PC;
        b_sel   = SRC_B_IMM;
        imm_sel = (op == OP_JAL) ? IMM_J : IMM_B;
        ALU_ena = 1'b1;
        unique case (op)
          OP_R:     state_d = f7_ok ? S_EXECUTE_R : S_ERROR;
          OP_I:     state_d = S_EXECUTE_I;
          OP_LOAD:  state_d = S_MEM_ADDR;
          OP_STORE: state_d = S_MEM_ADDR;
          OP_BR:    state_d = S_BRANCH;
          OP_JAL:   state_d = S_JAL;
          OP_JALR:  state_d = S_JALR;
          OP_LUI:   state_d = S_LUI;
          OP_AUIPC: state_d = S_AUIPC;
          default:  state_d = S_ERROR;
        endcase
      end
      S_EXECUTE_R: begin
        a_sel   = SRC_A_RF;
        cls     = CLS_R;
        ALU_ena = 1'b1;
        state_d = S_ALU_WRITEBACK;
      end
      S_EXECUTE_I: begin
        a_sel   = SRC_A_RF;
        b_sel   = SRC_B_IMM;
        cls     = CLS_I;
        ALU_ena = 1'b1;
        state_d = S_ALU_WRITEBACK;
      end
      S_ALU_WRITEBACK: begin
        res_sel   = RES_ALU_LAST;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        a_sel   = SRC_A_RF;
        b_sel   = SRC_B_IMM;
        imm_sel = (op == OP_STORE) ? IMM_S : IMM_I;
        ALU_ena = 1'b1;
        state_d = (op == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        msrc    = MEM_SRC_RESULT;
        res_sel = RES_ALU_LAST;
        if (mem_ready) begin
          mem_data_ena = 1'b1;
          state_d      = S_MEM_WRITEBACK;
        end
      end
      S_MEM_WRITE: begin
        mem_req    = 1'b1;
        mem_wr_ena = 1'b1;
        msrc       = MEM_SRC_RESULT;
        res_sel    = RES_ALU_LAST;
        if (mem_ready) state_d = S_FETCH;
      end
      S_MEM_WRITEBACK: begin
        res_sel   = RES_MEM_DATA;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        a_sel   = SRC_A_RF;
        imm_sel = IMM_B;
        cls     = CLS_SUB;
        if (br_bad) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_FETCH;
          if (br_taken) begin
            PC_ena  = 1'b1;
            res_sel = RES_ALU_LAST;
          end
        end
      end
      S_JAL: begin
        imm_sel = IMM_J;
        PC_ena  = 1'b1;
        res_sel = RES_ALU_LAST;
        state_d = S_LINK;
      end
      S_JALR: begin
        a_sel        = SRC_A_RF;
        b_sel        = SRC_B_IMM;
        PC_ena       = 1'b1;
        jalr_clr_lsb = 1'b1;
        state_d      = S_LINK;
      end
      S_LINK: begin
        a_sel   = SRC_A_OLD_PC;
        b_sel   = SRC_B_FOUR;
        ALU_ena = 1'b1;
        state_d = S_ALU_WRITEBACK;
      end
      S_LUI: begin
        a_sel   = SRC_A_ZERO;
        b_sel   = SRC_B_IMM;
        imm_sel = IMM_U;
        ALU_ena = 1'b1;
        state_d = S_ALU_WRITEBACK;
      end
      S_AUIPC: begin
        a_sel   = SRC_A_OLD_PC;
        b_sel   = SRC_B_IMM;
        imm_sel = IMM_U;
        ALU_ena = 1'b1;
        state_d = S_ALU_WRITEBACK;
      end
      default: state_d = S_ERROR;
    endcase
    if (mem_st && !mem_ready) begin
      cnt_d = cnt_q + 1'b1;
      if (MEM_TIMEOUT != 0 && cnt_q == CNT_LIM) begin
        state_d = S_ERROR;
        cnt_d   = '0;
      end
    end
    if (!ena) begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
    instr_retired = (state_d == S_FETCH) && (state_q != S_FETCH);
    if (!go) begin
      mem_req       = 1'b0;
      mem_wr_ena    = 1'b0;
      PC_ena        = 1'b0;
      IR_write      = 1'b0;
      ALU_ena       = 1'b0;
      mem_data_ena  = 1'b0;
      reg_write     = 1'b0;
      instr_retired = 1'b0;
    end
  end

  assign alu_src_a     = a_sel;
  assign alu_src_b     = b_sel;
  assign result_src    = res_sel;
  assign immediate_src = imm_sel;
  assign mem_src       = msrc;
  assign error         = (state_q == S_ERROR);
  assign state         = state_q;

endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// Directed bench for the multicycle controller: instruction
// flows, wait states, stall, reset and memory timeout.
module tb_rv32i_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alu_zero, alu_lt, alu_ltu, mem_ready;
  logic       mem_req, mem_wr_ena, mem_src, PC_ena, IR_write;
  logic       ALU_ena, mem_data_ena, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] immediate_src;
  logic [3:0] alu_control;
  logic       jalr_clr_lsb, instr_retired, error;
  logic [3:0] state;
  logic [7:0] strobes;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rv32i_multicycle_controller #(
    .MEM_TIMEOUT(16), .STRICT_DECODE(1), .ALU_CTRL_W(4)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .op(op),
    .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_wr_ena(mem_wr_ena), .mem_src(mem_src),
    .PC_ena(PC_ena), .IR_write(IR_write), .ALU_ena(ALU_ena),
    .mem_data_ena(mem_data_ena), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .immediate_src(immediate_src),
    .alu_control(alu_control), .jalr_clr_lsb(jalr_clr_lsb),
    .instr_retired(instr_retired), .error(error), .state(state)
  );

  // {mem_req,mem_wr_ena,PC_ena,IR_write,
  //  ALU_ena,mem_data_ena,reg_write,instr_retired}
  assign strobes = {mem_req, mem_wr_ena, PC_ena, IR_write,
                    ALU_ena, mem_data_ena, reg_write,
                    instr_retired};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic instr(input logic [6:0] o,
                       input logic [2:0] f3,
                       input logic [6:0] f7);
    op = o;
    funct3 = f3;
    funct7 = f7;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    ena = 1'b1;
    op = 7'b0010011;
    funct3 = 3'd0;
    funct7 = 7'd0;
    alu_zero = 1'b0;
    alu_lt = 1'b0;
    alu_ltu = 1'b0;
    mem_ready = 1'b1;
    tick();
    tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_strobes", 32'(strobes), 0);
    chk("rst_error", 32'(error), 0);
    rst = 1'b1;
    #1;

    // addi x1,x0,5
    instr(7'b0010011, 3'b000, 7'h00);
    chk("addi_fetch_st", 32'(state), 0);
    chk("addi_fetch_stb", 32'(strobes), 'hB0);
    chk("addi_fetch_b", 32'(alu_src_b), 2);
    tick();
    chk("addi_dec_st", 32'(state), 1);
    chk("addi_dec_stb", 32'(strobes), 'h08);
    chk("addi_dec_a", 32'(alu_src_a), 2);
    tick();
    chk("addi_exe_st", 32'(state), 3);
    chk("addi_exe_stb", 32'(strobes), 'h08);
    chk("addi_exe_b", 32'(alu_src_b), 1);
    chk("addi_exe_alu", 32'(alu_control), 0);
    tick();
    chk("addi_wb_st", 32'(state), 4);
    chk("addi_wb_stb", 32'(strobes), 'h03);
    chk("addi_wb_res", 32'(result_src), 2);
    tick();
    chk("addi_done_st", 32'(state), 0);
    chk("addi_done_stb", 32'(strobes), 'hB0);

    // lw with three wait cycles
    instr(7'b0000011, 3'b010, 7'h00);
    tick();
    tick();
    chk("lw_addr_st", 32'(state), 5);
    chk("lw_addr_imm", 32'(immediate_src), 0);
    chk("lw_addr_b", 32'(alu_src_b), 1);
    tick();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("lw_wait_st", 32'(state), 6);
      chk("lw_wait_stb", 32'(strobes), 'h80);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_rdy_st", 32'(state), 6);
    chk("lw_rdy_stb", 32'(strobes), 'h84);
    chk("lw_rdy_msrc", 32'(mem_src), 1);
    tick();
    chk("lw_wb_st", 32'(state), 8);
    chk("lw_wb_stb", 32'(strobes), 'h03);
    chk("lw_wb_res", 32'(result_src), 1);
    tick();
    chk("lw_done_st", 32'(state), 0);

    // beq taken
    instr(7'b1100011, 3'b000, 7'h00);
    alu_zero = 1'b1;
    #1;
    tick();
    tick();
    chk("beq_t_st", 32'(state), 9);
    chk("beq_t_stb", 32'(strobes), 'h21);
    chk("beq_t_res", 32'(result_src), 2);
    chk("beq_t_alu", 32'(alu_control), 1);
    tick();
    chk("beq_t_done", 32'(state), 0);

    // beq not taken
    alu_zero = 1'b0;
    #1;
    tick();
    tick();
    chk("beq_n_st", 32'(state), 9);
    chk("beq_n_stb", 32'(strobes), 'h01);
    chk("beq_n_res", 32'(result_src), 0);
    tick();
    chk("beq_n_done", 32'(state), 0);

    // blt taken, bgeu not taken
    instr(7'b1100011, 3'b100, 7'h00);
    alu_lt = 1'b1;
    alu_ltu = 1'b1;
    #1;
    tick();
    tick();
    chk("blt_stb", 32'(strobes), 'h21);
    tick();
    instr(7'b1100011, 3'b111, 7'h00);
    tick();
    tick();
    chk("bgeu_stb", 32'(strobes), 'h01);
    tick();
    alu_lt = 1'b0;
    alu_ltu = 1'b0;

    // jalr
    instr(7'b1100111, 3'b000, 7'h00);
    tick();
    tick();
    chk("jalr_st", 32'(state), 11);
    chk("jalr_stb", 32'(strobes), 'h20);
    chk("jalr_clr", 32'(jalr_clr_lsb), 1);
    chk("jalr_res", 32'(result_src), 0);
    tick();
    chk("link_st", 32'(state), 12);
    chk("link_stb", 32'(strobes), 'h08);
    chk("link_a", 32'(alu_src_a), 2);
    chk("link_b", 32'(alu_src_b), 2);
    tick();
    chk("jalr_wb_st", 32'(state), 4);
    chk("jalr_wb_stb", 32'(strobes), 'h03);
    tick();

    // lui
    instr(7'b0110111, 3'b000, 7'h00);
    tick();
    tick();
    chk("lui_st", 32'(state), 13);
    chk("lui_a", 32'(alu_src_a), 3);
    chk("lui_imm", 32'(immediate_src), 4);
    tick();
    tick();
    chk("lui_done", 32'(state), 0);

    // sub with 5-cycle stall in EXECUTE_R
    instr(7'b0110011, 3'b000, 7'h20);
    tick();
    tick();
    chk("sub_st", 32'(state), 2);
    chk("sub_alu", 32'(alu_control), 1);
    ena = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_st", 32'(state), 2);
      chk("stall_stb", 32'(strobes), 0);
      tick();
    end
    ena = 1'b1;
    #1;
    chk("resume_stb", 32'(strobes), 'h08);
    tick();
    chk("resume_wb", 32'(state), 4);
    tick();

    // srai
    instr(7'b0010011, 3'b101, 7'h20);
    tick();
    tick();
    chk("srai_alu", 32'(alu_control), 7);
    tick();
    tick();

    // illegal funct7 under strict decode, then reset
    instr(7'b0110011, 3'b000, 7'h01);
    tick();
    tick();
    chk("badf7_st", 32'(state), 15);
    chk("badf7_err", 32'(error), 1);
    chk("badf7_stb", 32'(strobes), 0);
    rst = 1'b0;
    #1;
    chk("badf7_rst_st", 32'(state), 0);
    chk("badf7_rst_err", 32'(error), 0);
    tick();
    rst = 1'b1;
    #1;

    // sw, reset during write wait
    instr(7'b0100011, 3'b010, 7'h00);
    tick();
    tick();
    chk("sw_addr_imm", 32'(immediate_src), 1);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("sw_wait_st", 32'(state), 7);
    chk("sw_wait_stb", 32'(strobes), 'hC0);
    tick();
    rst = 1'b0;
    #1;
    chk("sw_rst_wr", 32'(mem_wr_ena), 0);
    chk("sw_rst_stb", 32'(strobes), 0);
    tick();
    rst = 1'b1;
    #1;
    chk("sw_rel_st", 32'(state), 0);

    // fetch timeout with mem_ready stuck low
    for (int i = 0; i < 16; i++) begin
      chk("to_wait_st", 32'(state), 0);
      chk("to_wait_stb", 32'(strobes), 'h80);
      tick();
    end
    chk("to_err_st", 32'(state), 15);
    chk("to_err_stb", 32'(strobes), 0);
    mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 100; i++) begin
      chk("to_sticky", 32'(error), 1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
